pzcorebus_command_arbiter: RTL and testbench
============================================

Name: pzcorebus_command_arbiter

Overview:
- N-to-1 arbiter for the corebus request path: command and request-data channels from N requesters onto one downstream port.
- Round-robin grant per command. Grant is locked through all data beats of a write-class command.
- Requester index is prepended to the command ID. Responses are routed back to the requester by that index.
- Sits between core-side masters and a shared CSR or memory target.

Parameters:
- N, 4, number of requesters (2..16).
- PORT_W, (N==1)?1:$clog2(N), requester-index width.
- ID_WIDTH, 16, requester-side ID width. Downstream ID is ID_WIDTH+PORT_W.
- CMD_PAYLOAD_W, 96, opaque command payload width (address, length, info) forwarded unchanged.
- DATA_PAYLOAD_W, 160, opaque request-data payload width (data, byte enable) forwarded unchanged.
- RESP_PAYLOAD_W, 136, opaque response payload width (type, error, data, info, last) forwarded unchanged.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, asynchronous active-high reset.
- i_mcmd_valid, input, N, per-requester command valid.
- o_mcmd_accept, output, N, per-requester command accept.
- i_mcmd, input, N*4, per-requester 4-bit command type.
- i_mid, input, N*ID_WIDTH, per-requester command ID.
- i_mcmd_payload, input, N*CMD_PAYLOAD_W, per-requester payload.
- i_mdata_valid, input, N, per-requester data valid.
- o_mdata_accept, output, N, per-requester data accept.
- i_mdata_last, input, N, last beat of the burst.
- i_mdata_payload, input, N*DATA_PAYLOAD_W, per-requester data payload.
- o_mcmd_valid, output, 1, downstream command valid.
- i_mcmd_accept, input, 1, downstream command accept.
- o_mcmd, output, 4, forwarded command type.
- o_mid, output, ID_WIDTH+PORT_W, {grant index, requester ID}.
- o_mcmd_payload, output, CMD_PAYLOAD_W, forwarded payload.
- o_mdata_valid, output, 1, downstream data valid.
- i_mdata_accept, input, 1, downstream data accept.
- o_mdata_last, output, 1, forwarded last.
- o_mdata_payload, output, DATA_PAYLOAD_W, forwarded data.
- i_sresp_valid, input, 1, downstream response valid.
- o_sresp_accept, output, 1, downstream response accept.
- i_sid, input, ID_WIDTH+PORT_W, response ID.
- i_sresp_payload, input, RESP_PAYLOAD_W, response payload.
- o_sresp_valid, output, N, per-requester response valid.
- i_sresp_accept, input, N, per-requester response accept.
- o_sid, output, ID_WIDTH, response ID with index stripped (broadcast to all requesters).
- o_sresp_payload, output, RESP_PAYLOAD_W, response payload (broadcast to all requesters).

Behaviour:
- Clock and reset: i_clk; i_rst asynchronous active-high. Reset-only flops: state, grant index, RR pointer.
- Write-class command: command bit 2 (data bit) = 1, i.e. WRITE, FULL_WRITE, BROADCAST, ATOMIC and their non-posted forms. READ and MESSAGE carry no data.
- State machine:
  - IDLE → HOLD: some i_mcmd_valid set and no downstream handshake this cycle.
  - IDLE → DATA: write-class command handshakes this cycle.
  - IDLE → IDLE: non-data command handshakes this cycle.
  - HOLD → DATA: handshake of a write-class command.
  - HOLD → IDLE: handshake of any other command.
  - DATA → IDLE: o_mdata_valid & i_mdata_accept & o_mdata_last.
- Arbitration in IDLE is combinational, zero latency. Winner is the first valid requester at or after the RR pointer, wrapping N-1 → 0.
- In HOLD the registered grant index is used, so o_mcmd_valid and its fields stay stable until accepted, even if a higher-priority request arrives. Requesters must not drop valid before accept.
- On every command handshake, RR pointer = grant+1 mod N.
- o_mcmd_valid = i_mcmd_valid[grant] in IDLE/HOLD; 0 in DATA.
- o_mcmd_accept[grant] = i_mcmd_accept in IDLE/HOLD; all other accept bits are 0.
- Data channel:
  - Forwarded only in DATA, from the locked grant index.
  - Other requesters' data valids are ignored (accept 0).
  - Data presented before its command is accepted waits. In the handshake cycle that enters DATA, data is still not forwarded; the first beat goes out the cycle after.
- A non-data command handshake in IDLE/HOLD leaves o_mdata_valid = 0 throughout.
- Response routing: dest = i_sid[ID_WIDTH+:PORT_W].
  - o_sresp_valid[dest] = i_sresp_valid.
  - o_sresp_accept = i_sresp_accept[dest].
  - dest ≥ N: response is dropped (accept 1, no valid out).
  - Response path is combinational and independent of state.
- Reset values: all valid and accept outputs 0, state IDLE, pointer 0, grant 0.
- Reset mid-burst returns to IDLE. No partial beats are replayed.

Optional Feature:
- Macro: PZCOREBUS_COMMAND_ARBITER_GRANT_COUNTER_EN.
- Defined:
  - Adds input i_counter_clear (1 bit) and output o_grant_count (N*16 bits).
  - Per-requester 16-bit saturating counters (stop at 0xFFFF), +1 per command handshake of that requester.
  - Clear is synchronous and takes priority over increment. Counters reset to 0.
- Undefined: neither port nor the counters exist. Behaviour is otherwise identical.

Test Plan:
- RR fairness: all 4 requesters drive READ continuously, downstream accept=1 → grants 0,1,2,3,0 on consecutive cycles; o_mid[17:16] matches the grant.
- Write lock: req1 WRITE with a 3-beat burst, req2 READ pending → req2's command is not forwarded until the cycle after req1's beat with last=1; req2's data accept stays 0.
- Backpressure hold: req2 valid and granted, i_mcmd_accept=0 for 5 cycles, req0 asserts valid in cycle 2 → o_mid stays {2,id} until accept; req0 is granted next.
- Response routing: i_sid={3,16'h00AB} with i_sresp_accept[3]=0 for 2 cycles → o_sresp_valid=4'b1000, o_sid=16'h00AB, o_sresp_accept=0 then 1.
- Reset mid-burst: assert i_rst after beat 1 of 4 → all valids 0 immediately; a post-reset READ from req0 is granted in its first valid cycle.
- Counters (macro on): 70000 grants to req0 → count 0xFFFF; i_counter_clear → 0 next cycle.

Source files
------------

// File: rtl/pzcorebus_command_arbiter.sv
// pzcorebus_command_arbiter
//   N-to-1 arbiter for the corebus request path. Commands from N requesters
//   are granted round-robin; a write-class command locks the grant until its
//   last data beat is accepted. The requester index is prepended to the
//   downstream command ID, and responses are steered back by that index.
//
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_mcmd_valid/o_mcmd_accept      per-requester command handshake (N)
//   i_mcmd, i_mid, i_mcmd_payload   per-requester command fields (packed N-wide)
//   i_mdata_valid/o_mdata_accept    per-requester data handshake (N)
//   i_mdata_last, i_mdata_payload   per-requester data fields
//   o_mcmd_valid/i_mcmd_accept      downstream command handshake
//   o_mcmd, o_mid, o_mcmd_payload   downstream command, o_mid = {grant, id}
//   o_mdata_valid/i_mdata_accept    downstream data handshake
//   o_mdata_last, o_mdata_payload   downstream data fields
//   i_sresp_valid/o_sresp_accept    downstream response handshake
//   i_sid, i_sresp_payload          downstream response fields
//   o_sresp_valid/i_sresp_accept    per-requester response handshake (N)
//   o_sid, o_sresp_payload          response fields, broadcast to requesters
//
// Optional feature (macro PZCOREBUS_COMMAND_ARBITER_GRANT_COUNTER_EN)
//   i_counter_clear                 synchronous clear of all grant counters
//   o_grant_count                   N x 16-bit saturating grant counters
module pzcorebus_command_arbiter #(
    parameter int unsigned N              = 4,
    parameter int unsigned PORT_W         = (N == 1) ? 1 : $clog2(N),
    parameter int unsigned ID_WIDTH       = 16,
    parameter int unsigned CMD_PAYLOAD_W  = 96,
    parameter int unsigned DATA_PAYLOAD_W = 160,
    parameter int unsigned RESP_PAYLOAD_W = 136
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
`ifdef PZCOREBUS_COMMAND_ARBITER_GRANT_COUNTER_EN
    input  logic                          i_counter_clear,
    output logic [N*16-1:0]               o_grant_count,
`endif
    input  logic [N-1:0]                  i_mcmd_valid,
    output logic [N-1:0]                  o_mcmd_accept,
    input  logic [N*4-1:0]                i_mcmd,
    input  logic [N*ID_WIDTH-1:0]         i_mid,
    input  logic [N*CMD_PAYLOAD_W-1:0]    i_mcmd_payload,
    input  logic [N-1:0]                  i_mdata_valid,
    output logic [N-1:0]                  o_mdata_accept,
    input  logic [N-1:0]                  i_mdata_last,
    input  logic [N*DATA_PAYLOAD_W-1:0]   i_mdata_payload,
    output logic                          o_mcmd_valid,
    input  logic                          i_mcmd_accept,
    output logic [3:0]                    o_mcmd,
    output logic [ID_WIDTH+PORT_W-1:0]    o_mid,
    output logic [CMD_PAYLOAD_W-1:0]      o_mcmd_payload,
    output logic                          o_mdata_valid,
    input  logic                          i_mdata_accept,
    output logic                          o_mdata_last,
    output logic [DATA_PAYLOAD_W-1:0]     o_mdata_payload,
    input  logic                          i_sresp_valid,
    output logic                          o_sresp_accept,
    input  logic [ID_WIDTH+PORT_W-1:0]    i_sid,
    input  logic [RESP_PAYLOAD_W-1:0]     i_sresp_payload,
    output logic [N-1:0]                  o_sresp_valid,
    input  logic [N-1:0]                  i_sresp_accept,
    output logic [ID_WIDTH-1:0]           o_sid,
    output logic [RESP_PAYLOAD_W-1:0]     o_sresp_payload
);

    localparam int unsigned CMD_W     = 4;
    localparam int unsigned CNT_W     = 16;
    // Command bit 2 marks a command that carries request data.
    localparam int unsigned DATA_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   grant_q, grant_d;
    logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [PORT_W-1:0]   arb_grant;
    logic [PORT_W-1:0]   hi_grant, lo_grant;
    logic                hi_found, lo_found;
    logic [PORT_W-1:0]   grant;

    logic                        sel_mcmd_valid;
    logic [CMD_W-1:0]            sel_mcmd;
    logic [ID_WIDTH-1:0]         sel_mid;
    logic [CMD_PAYLOAD_W-1:0]    sel_mcmd_payload;
    logic                        sel_mdata_valid;
    logic                        sel_mdata_last;
    logic [DATA_PAYLOAD_W-1:0]   sel_mdata_payload;

    logic                active;
    logic                cmd_phase;
    logic                data_phase;
    logic                cmd_hs;
    logic                data_last_hs;
    logic [PORT_W-1:0]   resp_dest;

    // Round-robin search: first valid at/after the pointer, else first valid overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_grant = '0;
        lo_grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_mcmd_valid[i]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_grant = PORT_W'(i);
                end
                if (!hi_found && (PORT_W'(i) >= rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_grant = PORT_W'(i);
                end
            end
        end
        arb_grant = hi_found ? hi_grant : lo_grant;
    end

    // Only IDLE arbitrates live; HOLD and DATA keep the registered winner.
    assign grant = (state_q == IDLE) ? arb_grant : grant_q;

    // Command field mux for the current grant.
    always_comb begin
        sel_mcmd_valid   = 1'b0;
        sel_mcmd         = '0;
        sel_mid          = '0;
        sel_mcmd_payload = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == PORT_W'(i)) begin
                sel_mcmd_valid   = i_mcmd_valid[i];
                sel_mcmd         = i_mcmd[i*CMD_W +: CMD_W];
                sel_mid          = i_mid[i*ID_WIDTH +: ID_WIDTH];
                sel_mcmd_payload = i_mcmd_payload[i*CMD_PAYLOAD_W +: CMD_PAYLOAD_W];
            end
        end
    end

    // Data field mux for the locked grant.
    always_comb begin
        sel_mdata_valid   = 1'b0;
        sel_mdata_last    = 1'b0;
        sel_mdata_payload = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q == PORT_W'(i)) begin
                sel_mdata_valid   = i_mdata_valid[i];
                sel_mdata_last    = i_mdata_last[i];
                sel_mdata_payload = i_mdata_payload[i*DATA_PAYLOAD_W +: DATA_PAYLOAD_W];
            end
        end
    end

    // Every handshake output is held low while reset is asserted.
    assign active     = !i_rst;
    assign cmd_phase  = active && (state_q != DATA);
    assign data_phase = active && (state_q == DATA);

    // Downstream command and data channels.
    always_comb begin
        o_mcmd_valid    = cmd_phase && sel_mcmd_valid;
        o_mcmd          = sel_mcmd;
        o_mid           = {grant, sel_mid};
        o_mcmd_payload  = sel_mcmd_payload;
        o_mdata_valid   = data_phase && sel_mdata_valid;
        o_mdata_last    = sel_mdata_last;
        o_mdata_payload = sel_mdata_payload;
        o_mcmd_accept   = '0;
        o_mdata_accept  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            o_mcmd_accept[i]  = cmd_phase  && (grant   == PORT_W'(i)) && i_mcmd_accept;
            o_mdata_accept[i] = data_phase && (grant_q == PORT_W'(i)) && i_mdata_accept;
        end
    end

    assign cmd_hs       = o_mcmd_valid && i_mcmd_accept;
    assign data_last_hs = o_mdata_valid && i_mdata_accept && o_mdata_last;

    // Response steering by the index field; an index with no requester is sunk.
    assign resp_dest = i_sid[ID_WIDTH +: PORT_W];

    always_comb begin
        o_sid           = i_sid[ID_WIDTH-1:0];
        o_sresp_payload = i_sresp_payload;
        o_sresp_valid   = '0;
        o_sresp_accept  = active;
        for (int unsigned i = 0; i < N; i++) begin
            if (resp_dest == PORT_W'(i)) begin
                o_sresp_valid[i] = active && i_sresp_valid;
                o_sresp_accept   = active && i_sresp_accept[i];
            end
        end
    end

    // Next-state, grant and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                grant_d = arb_grant;
                if (cmd_hs) begin
                    state_d = sel_mcmd[DATA_BIT] ? DATA : IDLE;
                end else if (|i_mcmd_valid) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cmd_hs) begin
                    state_d = sel_mcmd[DATA_BIT] ? DATA : IDLE;
                end
            end
            DATA: begin
                if (data_last_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cmd_hs) begin
            rr_ptr_d = (grant == PORT_W'(N - 1)) ? '0 : grant + PORT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef PZCOREBUS_COMMAND_ARBITER_GRANT_COUNTER_EN
    // Per-requester saturating grant counters; clear wins over increment.
    for (genvar g = 0; g < N; g++) begin : g_grant_count
        logic [CNT_W-1:0] count_q;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                count_q <= '0;
            end else if (i_counter_clear) begin
                count_q <= '0;
            end else if (cmd_hs && (grant == PORT_W'(g)) && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + CNT_W'(1);
            end
        end

        assign o_grant_count[g*CNT_W +: CNT_W] = count_q;
    end
`endif

endmodule

// File: tb/tb_pzcorebus_command_arbiter.sv
// Directed self-checking bench for pzcorebus_command_arbiter (N=4, ID_WIDTH=16).
module tb_pzcorebus_command_arbiter;

    localparam int N   = 4;
    localparam int IDW = 16;
    localparam int CPW = 96;
    localparam int DPW = 160;
    localparam int RPW = 136;
    localparam logic [3:0] RD = 4'b0001;
    localparam logic [3:0] WR = 4'b0100;

    logic               clk;
    logic               rst;
    logic [N-1:0]       mcmd_valid_in;
    logic [N-1:0]       mcmd_accept_out;
    logic [N*4-1:0]     mcmd_in;
    logic [N*IDW-1:0]   mid_in;
    logic [N*CPW-1:0]   mcmd_payload_in;
    logic [N-1:0]       mdata_valid_in;
    logic [N-1:0]       mdata_accept_out;
    logic [N-1:0]       mdata_last_in;
    logic [N*DPW-1:0]   mdata_payload_in;
    logic               mcmd_valid_out;
    logic               mcmd_accept_in;
    logic [3:0]         mcmd_out;
    logic [IDW+1:0]     mid_out;
    logic [CPW-1:0]     mcmd_payload_out;
    logic               mdata_valid_out;
    logic               mdata_accept_in;
    logic               mdata_last_out;
    logic [DPW-1:0]     mdata_payload_out;
    logic               sresp_valid_in;
    logic               sresp_accept_out;
    logic [IDW+1:0]     sid_in;
    logic [RPW-1:0]     sresp_payload_in;
    logic [N-1:0]       sresp_valid_out;
    logic [N-1:0]       sresp_accept_in;
    logic [IDW-1:0]     sid_out;
    logic [RPW-1:0]     sresp_payload_out;
`ifdef PZCOREBUS_COMMAND_ARBITER_GRANT_COUNTER_EN
    logic               counter_clear;
    logic [N*16-1:0]    grant_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    pzcorebus_command_arbiter #(
        .N              (N),
        .ID_WIDTH       (IDW),
        .CMD_PAYLOAD_W  (CPW),
        .DATA_PAYLOAD_W (DPW),
        .RESP_PAYLOAD_W (RPW)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
`ifdef PZCOREBUS_COMMAND_ARBITER_GRANT_COUNTER_EN
        .i_counter_clear (counter_clear),
        .o_grant_count   (grant_count),
`endif
        .i_mcmd_valid    (mcmd_valid_in),
        .o_mcmd_accept   (mcmd_accept_out),
        .i_mcmd          (mcmd_in),
        .i_mid           (mid_in),
        .i_mcmd_payload  (mcmd_payload_in),
        .i_mdata_valid   (mdata_valid_in),
        .o_mdata_accept  (mdata_accept_out),
        .i_mdata_last    (mdata_last_in),
        .i_mdata_payload (mdata_payload_in),
        .o_mcmd_valid    (mcmd_valid_out),
        .i_mcmd_accept   (mcmd_accept_in),
        .o_mcmd          (mcmd_out),
        .o_mid           (mid_out),
        .o_mcmd_payload  (mcmd_payload_out),
        .o_mdata_valid   (mdata_valid_out),
        .i_mdata_accept  (mdata_accept_in),
        .o_mdata_last    (mdata_last_out),
        .o_mdata_payload (mdata_payload_out),
        .i_sresp_valid   (sresp_valid_in),
        .o_sresp_accept  (sresp_accept_out),
        .i_sid           (sid_in),
        .i_sresp_payload (sresp_payload_in),
        .o_sresp_valid   (sresp_valid_out),
        .i_sresp_accept  (sresp_accept_in),
        .o_sid           (sid_out),
        .o_sresp_payload (sresp_payload_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic v, input logic [3:0] c, input logic [15:0] id);
        mcmd_valid_in[i]               = v;
        mcmd_in[i*4 +: 4]              = c;
        mid_in[i*IDW +: IDW]           = id;
        mcmd_payload_in[i*CPW +: CPW]  = CPW'(64'hC0DE_0000_0000_0000 | 64'(i));
    endtask

    task automatic set_data(input int i, input logic v, input logic last, input logic [63:0] d);
        mdata_valid_in[i]               = v;
        mdata_last_in[i]                = last;
        mdata_payload_in[i*DPW +: DPW]  = DPW'(d);
    endtask

    function automatic logic [63:0] mid_exp(input int g, input logic [15:0] id);
        return 64'({2'(g), id});
    endfunction

    initial begin
        rst = 1'b1;
        mcmd_valid_in = '0; mcmd_in = '0; mid_in = '0; mcmd_payload_in = '0;
        mdata_valid_in = '0; mdata_last_in = '0; mdata_payload_in = '0;
        mcmd_accept_in = 1'b0; mdata_accept_in = 1'b0;
        sresp_valid_in = 1'b0; sid_in = '0; sresp_payload_in = '0; sresp_accept_in = '0;
`ifdef PZCOREBUS_COMMAND_ARBITER_GRANT_COUNTER_EN
        counter_clear = 1'b0;
`endif
        #2;
        check("rst_mcmd_valid",   64'(mcmd_valid_out),   64'd0);
        check("rst_mcmd_accept",  64'(mcmd_accept_out),  64'd0);
        check("rst_mdata_valid",  64'(mdata_valid_out),  64'd0);
        check("rst_mdata_accept", 64'(mdata_accept_out), 64'd0);
        check("rst_sresp_valid",  64'(sresp_valid_out),  64'd0);
        tick(); tick();
        rst = 1'b0;

        // Round-robin: all four requesters hold READ, downstream always accepts.
        for (int i = 0; i < N; i++) set_cmd(i, 1'b1, RD, 16'h1000 + 16'(i));
        mcmd_accept_in = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % N;
            check($sformatf("rr_mid_%0d", k),    64'(mid_out),         mid_exp(g, 16'h1000 + 16'(g)));
            check($sformatf("rr_accept_%0d", k), 64'(mcmd_accept_out), 64'(4'b0001 << g));
            check($sformatf("rr_valid_%0d", k),  64'(mcmd_valid_out),  64'd1);
            tick();
        end
        // Last handshake was requester 0, so the pointer now sits at 1.
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, RD, 16'h0);
        mcmd_accept_in = 1'b0;
        tick();

        // Write lock: req1 WRITE with 3 beats, req2 READ pending with stray data.
        set_cmd(1, 1'b1, WR, 16'h0011);
        set_cmd(2, 1'b1, RD, 16'h0022);
        set_data(1, 1'b1, 1'b0, 64'hD0);
        set_data(2, 1'b1, 1'b1, 64'hEE);
        mcmd_accept_in  = 1'b1;
        mdata_accept_in = 1'b1;
        #1;
        check("wl_cmd_mid",      64'(mid_out),          mid_exp(1, 16'h0011));
        check("wl_cmd_type",     64'(mcmd_out),         64'(WR));
        check("wl_no_data_yet",  64'(mdata_valid_out),  64'd0);
        check("wl_daccept_none", 64'(mdata_accept_out), 64'd0);
        tick();
        set_cmd(1, 1'b0, WR, 16'h0011);
        #1;
        for (int b = 0; b < 3; b++) begin
            set_data(1, 1'b1, (b == 2), 64'hD0 + 64'(b));
            #1;
            check($sformatf("wl_beat%0d_valid", b),   64'(mdata_valid_out),        64'd1);
            check($sformatf("wl_beat%0d_data", b),    mdata_payload_out[63:0],     64'hD0 + 64'(b));
            check($sformatf("wl_beat%0d_last", b),    64'(mdata_last_out),         64'(b == 2));
            check($sformatf("wl_beat%0d_daccept", b), 64'(mdata_accept_out),       64'b0010);
            check($sformatf("wl_beat%0d_cmdblk", b),  64'(mcmd_valid_out),         64'd0);
            tick();
        end
        set_data(1, 1'b0, 1'b0, 64'h0);
        #1;
        check("wl_req2_mid",     64'(mid_out),          mid_exp(2, 16'h0022));
        check("wl_req2_accept",  64'(mcmd_accept_out),  64'b0100);
        check("wl_req2_no_data", 64'(mdata_accept_out), 64'd0);
        check("wl_req2_dvalid",  64'(mdata_valid_out),  64'd0);
        tick();
        set_cmd(2, 1'b0, RD, 16'h0);
        set_data(2, 1'b0, 1'b0, 64'h0);
        mcmd_accept_in  = 1'b0;
        mdata_accept_in = 1'b0;

        // Backpressure: req2 stalls 5 cycles, req0 joins in cycle 2 (pointer at 3).
        set_cmd(2, 1'b1, RD, 16'h0033);
        #1;
        check("bp_c1_mid",    64'(mid_out),         mid_exp(2, 16'h0033));
        check("bp_c1_accept", 64'(mcmd_accept_out), 64'd0);
        tick();
        set_cmd(0, 1'b1, RD, 16'h0044);
        for (int c = 2; c <= 5; c++) begin
            #1;
            check($sformatf("bp_c%0d_mid", c),   64'(mid_out),        mid_exp(2, 16'h0033));
            check($sformatf("bp_c%0d_valid", c), 64'(mcmd_valid_out), 64'd1);
            tick();
        end
        mcmd_accept_in = 1'b1;
        #1;
        check("bp_acc_mid",    64'(mid_out),         mid_exp(2, 16'h0033));
        check("bp_acc_accept", 64'(mcmd_accept_out), 64'b0100);
        tick();
        set_cmd(2, 1'b0, RD, 16'h0);
        #1;
        check("bp_next_mid",    64'(mid_out),         mid_exp(0, 16'h0044));
        check("bp_next_accept", 64'(mcmd_accept_out), 64'b0001);
        tick();
        set_cmd(0, 1'b0, RD, 16'h0);
        mcmd_accept_in = 1'b0;

        // Response routing to requester 3, which stalls two cycles.
        sresp_valid_in   = 1'b1;
        sid_in           = {2'd3, 16'h00AB};
        sresp_payload_in = RPW'(64'h5EED_F00D);
        sresp_accept_in  = 4'b0111;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("rs_valid_%0d", c),  64'(sresp_valid_out),  64'b1000);
            check($sformatf("rs_sid_%0d", c),    64'(sid_out),          64'h00AB);
            check($sformatf("rs_accept_%0d", c), 64'(sresp_accept_out), 64'd0);
            tick();
        end
        sresp_accept_in = 4'b1000;
        #1;
        check("rs_accept_go", 64'(sresp_accept_out),       64'd1);
        check("rs_payload",   sresp_payload_out[63:0],     64'h5EED_F00D);
        sid_in          = {2'd1, 16'h0CD0};
        sresp_accept_in = 4'b0010;
        #1;
        check("rs1_valid",  64'(sresp_valid_out),  64'b0010);
        check("rs1_accept", 64'(sresp_accept_out), 64'd1);
        tick();
        sresp_valid_in = 1'b0;

        // Reset mid-burst: req0 WRITE (pointer at 1 wraps to 0), reset after beat 1 of 4.
        set_cmd(0, 1'b1, WR, 16'h0055);
        mcmd_accept_in  = 1'b1;
        mdata_accept_in = 1'b1;
        set_data(0, 1'b1, 1'b0, 64'hB1);
        #1;
        check("rmb_cmd_mid", 64'(mid_out), mid_exp(0, 16'h0055));
        tick();
        set_cmd(0, 1'b0, WR, 16'h0055);
        #1;
        check("rmb_beat1", 64'(mdata_valid_out), 64'd1);
        tick();
        rst = 1'b1;
        set_cmd(0, 1'b1, RD, 16'h0066);
        #1;
        check("rmb_rst_dvalid",  64'(mdata_valid_out),  64'd0);
        check("rmb_rst_cvalid",  64'(mcmd_valid_out),   64'd0);
        check("rmb_rst_daccept", 64'(mdata_accept_out), 64'd0);
        tick();
        rst = 1'b0;
        set_data(0, 1'b0, 1'b0, 64'h0);
        #1;
        check("rmb_post_valid",  64'(mcmd_valid_out),  64'd1);
        check("rmb_post_mid",    64'(mid_out),         mid_exp(0, 16'h0066));
        check("rmb_post_accept", 64'(mcmd_accept_out), 64'b0001);
        check("rmb_post_dvalid", 64'(mdata_valid_out), 64'd0);
        tick();

`ifdef PZCOREBUS_COMMAND_ARBITER_GRANT_COUNTER_EN
        // Requester 0 keeps issuing READs; its counter must saturate at 0xFFFF.
        repeat (70000) tick();
        check("cnt_sat",    64'(grant_count[15:0]),  64'hFFFF);
        check("cnt_other",  64'(grant_count[31:16]), 64'd0);
        counter_clear = 1'b1;
        tick();
        check("cnt_clear",  64'(grant_count[15:0]),  64'd0);
        counter_clear = 1'b0;
`endif
        set_cmd(0, 1'b0, RD, 16'h0);
        mcmd_accept_in  = 1'b0;
        mdata_accept_in = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
